// File: rtl/mdu_seq_if.sv
// Request/response bundle between the execute stage and the iterative MDU.
// master = core side (drives the request), slave = mdu_seq.
interface mdu_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      fn3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic            busy;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, flush, fn3, rs1_data, rs2_data,
    input  busy, stall, done, result
  );

  modport slave (
    input  start, flush, fn3, rs1_data, rs2_data,
    output busy, stall, done, result
  );
endinterface

// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply, restoring divide, 35-cycle latency.
// Stalls the core until done; optional MDU_EARLY_OUT_EN skips CALC for zero operands / zero divisor.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  mdu_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        fn3_q, fn3_d;
  logic [XLEN-1:0]   op1_q, op1_d, op2_q, op2_d;
  logic [XLEN-1:0]   mag_q, mag_d;  // multiplicand or divisor magnitude
  logic [XLEN-1:0]   sh_q, sh_d;    // multiplier (shifts right) or dividend/quotient (shifts left)
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [5:0]        cnt_q, cnt_d;
  logic              sgn1_q, sgn1_d, sgn2_q, sgn2_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              is_div, signed1, signed2, s1, s2, div0, early;
  logic [XLEN-1:0]   mag1, mag2, quot, rem, fix_res;
  logic [XLEN:0]     mul_sum, rem_sh, rem_sub;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    is_div  = fn3_q[2];
    signed1 = (fn3_q == 3'd1) || (fn3_q == 3'd2) || (fn3_q == 3'd4) || (fn3_q == 3'd6);
    signed2 = (fn3_q == 3'd1) || (fn3_q == 3'd4) || (fn3_q == 3'd6);
    s1      = signed1 & op1_q[XLEN-1];
    s2      = signed2 & op2_q[XLEN-1];
    mag1    = s1 ? -op1_q : op1_q;
    mag2    = s2 ? -op2_q : op2_q;
    div0    = (op2_q == '0);
`ifdef MDU_EARLY_OUT_EN
    early   = is_div ? div0 : ((op1_q == '0) || (op2_q == '0));
`else
    early   = 1'b0;
`endif

    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (sh_q[0] ? {1'b0, mag_q} : '0);
    // Partial remainder needs one extra bit after the shift when the divisor exceeds 2^(XLEN-1).
    rem_sh  = {acc_q[XLEN-1:0], sh_q[XLEN-1]};
    rem_sub = rem_sh - {1'b0, mag_q};

    prod    = (sgn1_q ^ sgn2_q) ? -acc_q : acc_q;
    quot    = (sgn1_q ^ sgn2_q) ? -sh_q : sh_q;
    rem     = sgn1_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    case (fn3_q)
      3'd0:       fix_res = prod[XLEN-1:0];
      3'd1, 3'd2,
      3'd3:       fix_res = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5: fix_res = div0 ? '1 : quot;
      default:    fix_res = div0 ? op1_q : rem;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    fn3_d    = fn3_q;
    op1_d    = op1_q;
    op2_d    = op2_q;
    mag_d    = mag_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sgn1_d   = sgn1_q;
    sgn2_d   = sgn2_q;
    result_d = result_q;

    case (state_q)
      IDLE: if (bus.start) begin
        state_d = PREP;
        fn3_d   = bus.fn3;
        op1_d   = bus.rs1_data;
        op2_d   = bus.rs2_data;
        cnt_d   = '0;
      end
      PREP: begin
        sgn1_d  = s1;
        sgn2_d  = s2;
        mag_d   = is_div ? mag2 : mag1;
        sh_d    = is_div ? mag1 : mag2;
        acc_d   = '0;
        state_d = early ? FIX : CALC;
      end
      CALC: begin
        if (is_div) begin
          if (rem_sh >= {1'b0, mag_q}) begin
            acc_d = {{XLEN{1'b0}}, rem_sub[XLEN-1:0]};
            sh_d  = {sh_q[XLEN-2:0], 1'b1};
          end else begin
            acc_d = {{XLEN{1'b0}}, rem_sh[XLEN-1:0]};
            sh_d  = {sh_q[XLEN-2:0], 1'b0};
          end
        end else begin
          acc_d = {mul_sum, acc_q[XLEN-1:1]};
          sh_d  = {1'b0, sh_q[XLEN-1:1]};
        end
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(XLEN-1)) state_d = FIX;
      end
      FIX: begin
        result_d = fix_res;
        state_d  = DONE;
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything, including a same-cycle start or the FIX result write.
    if (bus.flush) begin
      state_d  = IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      fn3_q    <= '0;
      op1_q    <= '0;
      op2_q    <= '0;
      mag_q    <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      sgn1_q   <= 1'b0;
      sgn2_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      fn3_q    <= fn3_d;
      op1_q    <= op1_d;
      op2_q    <= op2_d;
      mag_q    <= mag_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sgn1_q   <= sgn1_d;
      sgn2_q   <= sgn2_d;
      result_q <= result_d;
    end
  end

  assign bus.busy   = (state_q == PREP) || (state_q == CALC) || (state_q == FIX);
  assign bus.stall  = (bus.start && (state_q == IDLE)) || bus.busy;
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed RV32M vectors, latency/busy timing, flush, async reset, held start.
module tb_mdu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy;
  } exp_t;
  exp_t sb[$];

`ifdef MDU_EARLY_OUT_EN
  localparam int ZLAT = 3;
`else
  localparam int ZLAT = 35;
`endif

  mdu_seq_if #(.XLEN(32)) bus ();
  mdu_seq #(.XLEN(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_cnt = 0;
    end else begin
      if (bus.busy) busy_cnt++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_done: got done=1 expected no pulse (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", bus.result, e.res);
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          check("busy_cycles", 32'(busy_cnt), 32'(e.busy));
        end
      end
      if (!bus.busy && !bus.done) busy_cnt = 0;
    end
  end

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 100);
    if (!bus.done) begin
      tests++;
      fails++;
      $display("FAIL done_timeout: got no done within 100 cycles expected a pulse");
    end
  endtask

  // Accept edge leaves cyc=N in PREP (cycle 1); done in cycle lat means cyc = N + lat - 1.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    exp_t e;
    @(negedge clk);
    bus.fn3 = f; bus.rs1_data = a; bus.rs2_data = b; bus.start = 1'b1;
    #1 check("stall_on_start", {31'b0, bus.stall}, 32'd1);
    @(posedge clk);
    #1;
    e.res = exp; e.cyc = cyc + lat - 1; e.busy = lat - 1;
    sb.push_back(e);
    bus.start = 1'b0;
    wait_done();
    @(negedge clk);
  endtask

  localparam int NV = 19;
  logic [2:0]  v_fn [NV] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5, 3'd7,
                             3'd0, 3'd4, 3'd6, 3'd3, 3'd0, 3'd5, 3'd7, 3'd6, 3'd4};
  logic [31:0] v_a  [NV] = '{32'h7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                             32'hFFFF_FFF9, 32'h8000_0000, 32'h8000_0000, 32'd100, 32'd100,
                             32'h1234_5678, 32'd100, 32'hFFFF_FFFB, 32'h8000_0000, 32'h0001_0000,
                             32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'd7};
  logic [31:0] v_b  [NV] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h2, 32'h2,
                             32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,
                             32'h0, 32'd0, 32'd0, 32'h2, 32'h0001_0000,
                             32'h10, 32'h10, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
  logic [31:0] v_e  [NV] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                             32'hFFFF_FFFF, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'd100,
                             32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h1, 32'h0,
                             32'h0FFF_FFFF, 32'hF, 32'h1, 32'hFFFF_FFFD};
  bit          v_z  [NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   n;
    bus.start = 1'b0; bus.flush = 1'b0; bus.fn3 = '0; bus.rs1_data = '0; bus.rs2_data = '0;
    #3;
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++)
      issue(v_fn[i], v_a[i], v_b[i], v_e[i], v_z[i] ? ZLAT : 35);

    // Start held across a whole op: DONE-cycle start ignored, next IDLE cycle accepts.
    @(negedge clk);
    bus.fn3 = 3'd0; bus.rs1_data = 32'd3; bus.rs2_data = 32'd5; bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.res = 32'd15; e.cyc = cyc + 34; e.busy = 34; sb.push_back(e);
    e.cyc = cyc + 36 + 34; sb.push_back(e);
    wait_done();
    check("stall_in_done", {31'b0, bus.stall}, 32'd0);
    @(negedge clk);
    check("stall_idle_held", {31'b0, bus.stall}, 32'd1);
    wait_done();
    bus.start = 1'b0;
    repeat (40) @(negedge clk);

    // Flush at cycle 10 of a DIV.
    bus.fn3 = 3'd4; bus.rs1_data = 32'd20; bus.rs2_data = 32'd3; bus.start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    bus.start = 1'b0;
    while (cyc < n + 9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush_busy", {31'b0, bus.busy}, 32'd0);
    check("flush_result", bus.result, 32'd15);
    repeat (40) @(negedge clk);

    // Async reset at cycle 20 of a multiply.
    bus.fn3 = 3'd0; bus.rs1_data = 32'd9; bus.rs2_data = 32'd9; bus.start = 1'b1;
    @(posedge clk);
    #1 n = cyc;
    bus.start = 1'b0;
    while (cyc < n + 19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", {31'b0, bus.busy}, 32'd0);
    check("arst_done", {31'b0, bus.done}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(3'd0, 32'h7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 35);
    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative RV32M multiply/divide sequencer beside the execute-stage ALU. It accepts one M-extension operation per handshake and runs a radix-2 shift-add multiply or restoring divide over 32 iterations. It stalls the single-cycle core through `stall` until the result is ready, then presents a one-cycle `done` pulse with a held `result` for the write-back mux.

## Interface
- `XLEN`, default 32: operand and result width; only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request; sampled only in IDLE.
- `flush`  input  1  abort any operation in progress.
- `fn3`  input  3  RV32M funct3:
  - 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU;
  - 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `rs1_data`  input  32  multiplicand or dividend.
- `rs2_data`  input  32  multiplier or divisor.
- `busy`  output  1  an operation is in progress (PREP, CALC or FIX).
- `stall`  output  1  combinational: `(start && state==IDLE) || busy`. Freezes the PC and register write.
- `done`  output  1  one-cycle pulse when the result is valid.
- `result`  output  32  final value; held until the next accepted start.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- IDLE → PREP on `start`. Latch `fn3` and the operands, and clear the iteration counter.
- PREP:
  - Record the operand signs. Signed operands are MULH/MULHSU rs1, MULH rs2, and DIV/REM both operands.
  - Convert signed operands to magnitudes.
  - Clear the 64-bit accumulator.
  - Go to CALC.
- CALC, one step per cycle, 32 cycles. The 6-bit counter runs 0..31 and CALC → FIX when it equals 31.
  - Multiply: if `mplier[0]`, add `mcand` into `acc[63:32]` with carry; shift `{carry,acc}` right by 1.
  - Divide: shift `{rem,quot}` left by 1; if `rem ≥ divisor`, subtract and set `quot[0]`.
- FIX: apply sign correction.
  - Product is negated when the operand signs differ.
  - Quotient is negated when the signs differ.
  - Remainder takes the dividend's sign.
  - Then select the result: MUL low word; MULH/MULHSU/MULHU high word; DIV/DIVU quotient; REM/REMU remainder.
  - Divisor == 0 override: DIV/DIVU = 0xFFFF_FFFF, REM/REMU = rs1.
  - Overflow case DIV(0x8000_0000, 0xFFFF_FFFF) = 0x8000_0000 and REM = 0. This falls out of the magnitude algorithm with no special case.
- DONE: `done`=1 for exactly this cycle, then return to IDLE.
- `start` while busy or in DONE is ignored; the requester holds it until accepted.
- `flush` in any state forces IDLE on the next edge. `done` is suppressed, `result` is unchanged, and flush has priority over start in the same cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values.

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `result`=0, counter=0, accumulator=0.
- Start accepted at edge 0:
  - PREP cycle 1;
  - CALC cycles 2–33;
  - FIX cycle 34;
  - DONE cycle 35, with `done`=1 and `result` valid.
- Full latency is 35 cycles. Throughput is one operation per 36 cycles.
- `busy` is high in cycles 1–34 and low in DONE.
- `stall` is high from the start cycle through cycle 34.
- `result` is registered at the FIX→DONE edge.
- Back-to-back: a start asserted in the DONE cycle is ignored. The earliest accepted start is the first IDLE cycle.

## Configuration
- `MDU_EARLY_OUT_EN` defined: PREP → FIX directly, skipping CALC, when either:
  - a divide has divisor == 0, or
  - a multiply has either operand == 0.
  
  Early-out latency is 3 cycles (done in cycle 3). Results are identical to the full path.
- Undefined: every operation takes 35 cycles. The zero-divisor override still applies in FIX.

## Test plan
- MUL 7 × (−3) (0x0000_0007, 0xFFFF_FFFD) → `result` 0xFFFF_FFEB; `done` at cycle 35; `busy` high in cycles 1–34.
- MULHU 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE. MULH of the same operands → 0x0000_0000. MULHSU 0xFFFF_FFFF × 0x2 → 0xFFFF_FFFF.
- DIV −7/2 → 0xFFFF_FFFD and REM → 0xFFFF_FFFF. DIV 0x8000_0000 / 0xFFFF_FFFF → 0x8000_0000 with REM 0.
- DIVU 100/0 → 0xFFFF_FFFF and REMU 100/0 → 100.
  - Without `MDU_EARLY_OUT_EN`: `done` at cycle 35.
  - With it: `done` at cycle 3.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `done` pulse, `result` unchanged. Drop `rst_n` at cycle 20 of a second op → `busy`/`done`/`result` = 0 asynchronously.
- `start` held through the entire operation → exactly one `done`. A new start is accepted only in the first IDLE cycle after DONE.
